xg_mac_tx_arbiter: RTL and testbench

//  Frame-granular round-robin arbiter that shares one xg_mac_tx between N_PORTS 64-bit AXI-Stream sources.

---
 rtl/xg_mac_pkg.sv | 14 +
 rtl/xg_mac_tx_arbiter_rr.sv | 35 +++
 rtl/xg_mac_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_xg_mac_tx_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xg_mac_pkg.sv
// Shared types and widths for the xg_mac transmit path.
package xg_mac_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;
    localparam int ARB_IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/xg_mac_tx_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping modulo N.
module rr_arbiter
    import xg_mac_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = ARB_IDX_W
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_onehot_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic found;
    int   cand;

    always_comb begin
        gnt_onehot_o = '0;
        gnt_idx_o    = '0;
        found        = 1'b0;
        cand         = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req_i[cand]) begin
                found              = 1'b1;
                gnt_onehot_o[cand] = 1'b1;
                gnt_idx_o          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/xg_mac_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one xg_mac_tx between N_PORTS AXI-Stream sources.
// A grant is held from first beat to tlast; frames longer than MAX_BEATS are cut and drained.
module xg_mac_tx_arbiter
    import xg_mac_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int MAX_BEATS = 190,
    parameter int CNT_W     = 8
) (
    input  logic                           clock,
    input  logic                           aresetn,
    input  logic [N_PORTS*AXIS_DATA_W-1:0] saxis_tdata,
    input  logic [N_PORTS*AXIS_KEEP_W-1:0] saxis_tkeep,
    input  logic [N_PORTS-1:0]             saxis_tvalid,
    input  logic [N_PORTS-1:0]             saxis_tlast,
    input  logic [N_PORTS-1:0]             saxis_tuser,
    output logic [N_PORTS-1:0]             saxis_tready,
    output logic [AXIS_DATA_W-1:0]         maxis_tdata,
    output logic [AXIS_KEEP_W-1:0]         maxis_tkeep,
    output logic                           maxis_tvalid,
    output logic                           maxis_tlast,
    output logic                           maxis_tuser,
    input  logic                           maxis_tready,
    output logic [ARB_IDX_W-1:0]           grant_id,
    output logic                           trunc_pulse
);

    arb_state_t             state_q, state_d;
    logic [ARB_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ARB_IDX_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [N_PORTS-1:0]     arb_onehot;
    logic [ARB_IDX_W-1:0]   arb_idx;
    logic [N_PORTS-1:0]     grant_oh;
    logic [ARB_IDX_W-1:0]   next_ptr;
    logic [AXIS_DATA_W-1:0] src_tdata;
    logic [AXIS_KEEP_W-1:0] src_tkeep;
    logic                   src_tvalid, src_tlast, src_tuser;
    logic                   force_last;

    rr_arbiter #(
        .N     (N_PORTS),
        .IDX_W (ARB_IDX_W)
    ) u_rr (
        .req_i        (saxis_tvalid),
        .ptr_i        (rr_ptr_q),
        .gnt_onehot_o (arb_onehot),
        .gnt_idx_o    (arb_idx)
    );

    always_comb begin
        src_tdata  = '0;
        src_tkeep  = '0;
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
        src_tuser  = 1'b0;
        grant_oh   = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (grant_q == ARB_IDX_W'(p)) begin
                grant_oh[p] = 1'b1;
                src_tdata   = saxis_tdata[p*AXIS_DATA_W +: AXIS_DATA_W];
                src_tkeep   = saxis_tkeep[p*AXIS_KEEP_W +: AXIS_KEEP_W];
                src_tvalid  = saxis_tvalid[p];
                src_tlast   = saxis_tlast[p];
                src_tuser   = saxis_tuser[p];
            end
        end
    end

    assign next_ptr   = (grant_q == ARB_IDX_W'(N_PORTS - 1)) ? '0 : grant_q + ARB_IDX_W'(1);
    // cnt_q holds beats already accepted, so MAX_BEATS-1 marks the beat that must close the frame.
    assign force_last = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_BEATS - 1)) && !src_tlast;
    assign grant_id   = grant_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        maxis_tdata  = src_tdata;
        maxis_tkeep  = src_tkeep;
        maxis_tvalid = 1'b0;
        maxis_tlast  = src_tlast | force_last;
        maxis_tuser  = src_tuser | force_last;
        saxis_tready = '0;
        trunc_pulse  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|arb_onehot) begin
                    grant_d = arb_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                maxis_tvalid = src_tvalid;
                saxis_tready = grant_oh & {N_PORTS{maxis_tready}};
                if (src_tvalid && maxis_tready) begin
                    if (src_tlast) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                        cnt_d    = '0;
                    end else if (force_last) begin
                        state_d     = DRAIN;
                        cnt_d       = '0;
                        trunc_pulse = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Remainder of a truncated frame is accepted from the source and discarded.
                saxis_tready = grant_oh;
                if (src_tvalid && src_tlast) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_xg_mac_tx_arbiter.sv
// Directed bench for xg_mac_tx_arbiter: queued source frames, output monitor, per-scenario tasks.
module tb_xg_mac_tx_arbiter;
    import xg_mac_pkg::*;

    localparam int NP   = 4;
    localparam int MAXB = 190;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    logic            clock   = 1'b0;
    logic            aresetn = 1'b0;
    logic [NP*64-1:0] saxis_tdata;
    logic [NP*8-1:0] saxis_tkeep;
    logic [NP-1:0]   saxis_tvalid;
    logic [NP-1:0]   saxis_tlast;
    logic [NP-1:0]   saxis_tuser;
    logic [NP-1:0]   saxis_tready;
    logic [63:0]     maxis_tdata;
    logic [7:0]      maxis_tkeep;
    logic            maxis_tvalid;
    logic            maxis_tlast;
    logic            maxis_tuser;
    logic            maxis_tready;
    logic [2:0]      grant_id;
    logic            trunc_pulse;

    xg_mac_tx_arbiter #(.N_PORTS(NP), .MAX_BEATS(MAXB), .CNT_W(8)) dut (
        .clock        (clock),
        .aresetn      (aresetn),
        .saxis_tdata  (saxis_tdata),
        .saxis_tkeep  (saxis_tkeep),
        .saxis_tvalid (saxis_tvalid),
        .saxis_tlast  (saxis_tlast),
        .saxis_tuser  (saxis_tuser),
        .saxis_tready (saxis_tready),
        .maxis_tdata  (maxis_tdata),
        .maxis_tkeep  (maxis_tkeep),
        .maxis_tvalid (maxis_tvalid),
        .maxis_tlast  (maxis_tlast),
        .maxis_tuser  (maxis_tuser),
        .maxis_tready (maxis_tready),
        .grant_id     (grant_id),
        .trunc_pulse  (trunc_pulse)
    );

    initial forever #5 clock = ~clock;

    beat_t src_q[NP][$];
    beat_t exp_q[NP][$];
    beat_t out_q[NP][$];
    int    order_q[$];
    int    gap_q[$];

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    int fid = 0;
    int out_total = 0;
    int trunc_cnt = 0;
    int ack_err = 0;
    int inter_err = 0;
    int flush_req = 0;
    bit rdy_rand = 1'b0;
    bit gap_en = 1'b0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Source driver: holds each beat until it is accepted, optional random gaps between beats.
    initial begin
        logic [NP-1:0] hs_v;
        int flush_ack;
        flush_ack    = 0;
        saxis_tdata  = '0;
        saxis_tkeep  = '0;
        saxis_tvalid = '0;
        saxis_tlast  = '0;
        saxis_tuser  = '0;
        maxis_tready = 1'b1;
        forever begin
            @(negedge clock);
            hs_v = saxis_tvalid & saxis_tready;
            @(posedge clock);
            #1;
            if (flush_ack != flush_req) begin
                for (int p = 0; p < NP; p++) src_q[p].delete();
                saxis_tvalid = '0;
                hs_v = '0;
                flush_ack = flush_req;
            end
            for (int p = 0; p < NP; p++) begin
                if (hs_v[p] && src_q[p].size() > 0) begin
                    void'(src_q[p].pop_front());
                    saxis_tvalid[p] = 1'b0;
                end
                if (!saxis_tvalid[p] && src_q[p].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
                    saxis_tdata[64*p +: 64] = src_q[p][0].d;
                    saxis_tkeep[8*p +: 8]   = src_q[p][0].k;
                    saxis_tlast[p]          = src_q[p][0].l;
                    saxis_tuser[p]          = src_q[p][0].u;
                    saxis_tvalid[p]         = 1'b1;
                end
            end
            maxis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: attributes accepted beats to grant_id, records frame order and inter-frame gaps.
    initial begin
        beat_t b;
        bit    in_frame;
        int    frame_port;
        int    last_end;
        in_frame = 1'b0;
        frame_port = 0;
        last_end = 0;
        forever begin
            @(negedge clock);
            if (!aresetn) begin
                in_frame = 1'b0;
            end else begin
                if (trunc_pulse) trunc_cnt++;
                if ((saxis_tready & ~(4'b0001 << grant_id)) != 4'b0000) ack_err++;
                if (maxis_tvalid && maxis_tready && grant_id < 3'(NP)) begin
                    b.d = maxis_tdata;
                    b.k = maxis_tkeep;
                    b.l = maxis_tlast;
                    b.u = maxis_tuser;
                    out_q[grant_id].push_back(b);
                    out_total++;
                    if (!in_frame) begin
                        order_q.push_back(int'(grant_id));
                        gap_q.push_back(cyc - last_end);
                        frame_port = int'(grant_id);
                    end else if (int'(grant_id) != frame_port) begin
                        inter_err++;
                    end
                    in_frame = !maxis_tlast;
                    if (maxis_tlast) last_end = cyc;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks passed=%0d of %0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] kmask(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
        return r;
    endfunction

    function automatic int stream_bad(input int p);
        int n;
        int len;
        n   = (out_q[p].size() > exp_q[p].size()) ? out_q[p].size() - exp_q[p].size()
                                                  : exp_q[p].size() - out_q[p].size();
        len = (out_q[p].size() < exp_q[p].size()) ? out_q[p].size() : exp_q[p].size();
        for (int i = 0; i < len; i++) begin
            if (kmask(out_q[p][i].d, out_q[p][i].k) !== kmask(exp_q[p][i].d, exp_q[p][i].k) ||
                out_q[p][i].k !== exp_q[p][i].k || out_q[p][i].l !== exp_q[p][i].l ||
                out_q[p][i].u !== exp_q[p][i].u)
                n++;
        end
        return n;
    endfunction

    function automatic int exp_total();
        int n;
        n = 0;
        for (int p = 0; p < NP; p++) n += exp_q[p].size();
        return n;
    endfunction

    function automatic bit src_idle();
        bit e;
        e = (saxis_tvalid == '0);
        for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic clear_logs();
        for (int p = 0; p < NP; p++) begin
            out_q[p].delete();
            exp_q[p].delete();
        end
        order_q.delete();
        gap_q.delete();
        out_total = 0;
        trunc_cnt = 0;
        ack_err   = 0;
        inter_err = 0;
    endtask

    // Queue one source frame and its expected output (cut and error-flagged beyond MAXB beats).
    task automatic load_frame(input int p, input int nb, input logic [7:0] lk, input logic lu);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b.d = {8'(p), 8'(fid), 16'(i), $urandom()};
            b.k = (i == nb - 1) ? lk : 8'hFF;
            b.l = (i == nb - 1);
            b.u = (i == nb - 1) ? lu : 1'b0;
            src_q[p].push_back(b);
            if (i < MAXB) begin
                if (nb > MAXB && i == MAXB - 1) begin
                    b.l = 1'b1;
                    b.u = 1'b1;
                end
                exp_q[p].push_back(b);
            end
        end
        fid++;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n;
        n = 0;
        while ((!src_idle() || out_total < exp_total()) && n < budget) begin
            @(posedge clock);
            n++;
        end
        ok = (n < budget);
        repeat (4) @(posedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        chk_cnt++; if (saxis_tready !== 4'b0000) $display("FAIL reset_tready: got %b want 0000", saxis_tready); else pass_cnt++;
        chk_cnt++; if (maxis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", maxis_tvalid); else pass_cnt++;
        chk_cnt++; if (trunc_pulse !== 1'b0) $display("FAIL reset_trunc: got %b want 0", trunc_pulse); else pass_cnt++;
        chk_cnt++; if (grant_id !== 3'd0) $display("FAIL reset_grant: got %0d want 0", grant_id); else pass_cnt++;
        @(negedge clock);
        aresetn = 1'b1;
        @(posedge clock);
        #1;
        chk_cnt++; if (maxis_tvalid !== 1'b0) $display("FAIL idle_tvalid: got %b want 0", maxis_tvalid); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        bit ok;
        int want[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        @(posedge clock); #2;
        clear_logs();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) load_frame(p, 2, 8'hFF, 1'b0);
        wait_done(2000, ok);
        chk_cnt++; if (!ok) $display("FAIL rr_timeout: out beats %0d want %0d", out_total, exp_total()); else pass_cnt++;
        chk_cnt++; if (order_q.size() !== 8) $display("FAIL rr_frames: got %0d want 8", order_q.size()); else pass_cnt++;
        for (int i = 0; i < 8 && i < order_q.size(); i++) begin
            chk_cnt++; if (order_q[i] !== want[i]) $display("FAIL rr_order[%0d]: got %0d want %0d", i, order_q[i], want[i]); else pass_cnt++;
        end
        chk_cnt++; if (inter_err !== 0) $display("FAIL rr_interleave: got %0d want 0", inter_err); else pass_cnt++;
        for (int p = 0; p < NP; p++) begin
            chk_cnt++; if (stream_bad(p) !== 0) $display("FAIL rr_stream_p%0d: bad beats %0d want 0", p, stream_bad(p)); else pass_cnt++;
        end
    endtask

    task automatic test_single_port();
        bit ok;
        @(posedge clock); #2;
        clear_logs();
        for (int f = 0; f < 3; f++) load_frame(0, 8, 8'h0F, 1'b0);
        wait_done(2000, ok);
        chk_cnt++; if (!ok) $display("FAIL single_timeout: out beats %0d want 24", out_total); else pass_cnt++;
        chk_cnt++; if (out_q[0].size() !== 24) $display("FAIL single_beats: got %0d want 24", out_q[0].size()); else pass_cnt++;
        chk_cnt++; if (stream_bad(0) !== 0) $display("FAIL single_stream: bad beats %0d want 0", stream_bad(0)); else pass_cnt++;
        chk_cnt++; if (gap_q.size() !== 3) $display("FAIL single_frames: got %0d want 3", gap_q.size()); else pass_cnt++;
        for (int i = 1; i < 3 && i < gap_q.size(); i++) begin
            chk_cnt++; if (gap_q[i] !== 2) $display("FAIL single_gap[%0d]: got %0d cycles want 2", i, gap_q[i]); else pass_cnt++;
        end
        chk_cnt++; if (grant_id !== 3'd0) $display("FAIL single_grant: got %0d want 0", grant_id); else pass_cnt++;
    endtask

    task automatic test_truncation();
        bit ok;
        @(posedge clock); #2;
        clear_logs();
        load_frame(2, 200, 8'hFF, 1'b0);
        load_frame(2, 4, 8'h3F, 1'b0);
        wait_done(2000, ok);
        chk_cnt++; if (!ok) $display("FAIL trunc_timeout: out beats %0d want 194", out_total); else pass_cnt++;
        chk_cnt++; if (out_q[2].size() !== 194) $display("FAIL trunc_beats: got %0d want 194", out_q[2].size()); else pass_cnt++;
        if (out_q[2].size() > 189) begin
            chk_cnt++; if (out_q[2][189].l !== 1'b1) $display("FAIL trunc_last190: got %b want 1", out_q[2][189].l); else pass_cnt++;
            chk_cnt++; if (out_q[2][189].u !== 1'b1) $display("FAIL trunc_user190: got %b want 1", out_q[2][189].u); else pass_cnt++;
        end
        chk_cnt++; if (trunc_cnt !== 1) $display("FAIL trunc_pulses: got %0d want 1", trunc_cnt); else pass_cnt++;
        chk_cnt++; if (stream_bad(2) !== 0) $display("FAIL trunc_stream: bad beats %0d want 0", stream_bad(2)); else pass_cnt++;
    endtask

    task automatic test_exact_max();
        bit ok;
        @(posedge clock); #2;
        clear_logs();
        load_frame(1, 190, 8'h01, 1'b0);
        load_frame(1, 3, 8'hFF, 1'b1);
        wait_done(2000, ok);
        chk_cnt++; if (!ok) $display("FAIL exact_timeout: out beats %0d want 193", out_total); else pass_cnt++;
        chk_cnt++; if (trunc_cnt !== 0) $display("FAIL exact_pulses: got %0d want 0", trunc_cnt); else pass_cnt++;
        if (out_q[1].size() > 189) begin
            chk_cnt++; if (out_q[1][189].u !== 1'b0) $display("FAIL exact_user190: got %b want 0", out_q[1][189].u); else pass_cnt++;
        end
        chk_cnt++; if (stream_bad(1) !== 0) $display("FAIL exact_stream: bad beats %0d want 0", stream_bad(1)); else pass_cnt++;
        chk_cnt++; if (gap_q.size() !== 2 || gap_q[gap_q.size()-1] !== 2)
            $display("FAIL exact_gap: frames %0d last gap %0d want 2 frames gap 2", gap_q.size(), (gap_q.size() > 0) ? gap_q[gap_q.size()-1] : -1);
        else pass_cnt++;
    endtask

    task automatic test_random_backpressure();
        bit ok;
        int bytes;
        int r;
        @(posedge clock); #2;
        clear_logs();
        rdy_rand = 1'b1;
        gap_en   = 1'b1;
        for (int f = 0; f < 100; f++) begin
            bytes = $urandom_range(60, 1500);
            r     = bytes % 8;
            load_frame($urandom_range(0, NP - 1), (bytes + 7) / 8,
                       (r == 0) ? 8'hFF : 8'((1 << r) - 1), 1'($urandom_range(0, 1)));
        end
        wait_done(70000, ok);
        rdy_rand = 1'b0;
        gap_en   = 1'b0;
        chk_cnt++; if (!ok) $display("FAIL rand_timeout: out beats %0d want %0d", out_total, exp_total()); else pass_cnt++;
        for (int p = 0; p < NP; p++) begin
            chk_cnt++; if (stream_bad(p) !== 0) $display("FAIL rand_stream_p%0d: bad beats %0d want 0", p, stream_bad(p)); else pass_cnt++;
        end
        chk_cnt++; if (order_q.size() !== 100) $display("FAIL rand_frames: got %0d want 100", order_q.size()); else pass_cnt++;
        chk_cnt++; if (inter_err !== 0) $display("FAIL rand_interleave: got %0d want 0", inter_err); else pass_cnt++;
        chk_cnt++; if (ack_err !== 0) $display("FAIL rand_foreign_ack: got %0d want 0", ack_err); else pass_cnt++;
        chk_cnt++; if (trunc_cnt !== 0) $display("FAIL rand_pulses: got %0d want 0", trunc_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int n;
        @(posedge clock); #2;
        clear_logs();
        load_frame(1, 3, 8'hFF, 1'b0);
        wait_done(500, ok);
        chk_cnt++; if (!ok) $display("FAIL mid_pre_timeout: out beats %0d want 3", out_total); else pass_cnt++;
        load_frame(2, 20, 8'hFF, 1'b0);
        n = 0;
        while (out_q[2].size() < 4 && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk_cnt++; if (n >= 200) $display("FAIL mid_start_timeout: port2 beats %0d want 4", out_q[2].size()); else pass_cnt++;
        @(negedge clock);
        #2 aresetn = 1'b0;
        #1;
        chk_cnt++; if (saxis_tready !== 4'b0000) $display("FAIL mid_tready: got %b want 0000", saxis_tready); else pass_cnt++;
        chk_cnt++; if (maxis_tvalid !== 1'b0) $display("FAIL mid_tvalid: got %b want 0", maxis_tvalid); else pass_cnt++;
        chk_cnt++; if (grant_id !== 3'd0) $display("FAIL mid_grant: got %0d want 0", grant_id); else pass_cnt++;
        flush_req++;
        repeat (3) @(posedge clock);
        #2;
        clear_logs();
        @(negedge clock);
        aresetn = 1'b1;
        @(posedge clock); #2;
        load_frame(2, 3, 8'hFF, 1'b0);
        load_frame(0, 3, 8'hFF, 1'b0);
        wait_done(500, ok);
        chk_cnt++; if (!ok) $display("FAIL mid_post_timeout: out beats %0d want 6", out_total); else pass_cnt++;
        chk_cnt++; if (order_q.size() < 2 || order_q[0] !== 0 || order_q[1] !== 2)
            $display("FAIL mid_order: frames %0d first %0d want 2 frames first 0 then 2", order_q.size(), (order_q.size() > 0) ? order_q[0] : -1);
        else pass_cnt++;
        chk_cnt++; if (stream_bad(0) + stream_bad(2) !== 0) $display("FAIL mid_stream: bad beats %0d want 0", stream_bad(0) + stream_bad(2)); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_port();
        test_truncation();
        test_exact_max();
        test_random_backpressure();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
